// File: rtl/mem_bus_arbiter_pkg.sv
// ============================================================================
// Package : cpu_defs
// Shared definitions for the memory bus arbiter (line size, FSM states, ids).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs;

    localparam int LINE_WORDS = 4;

    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_RESP = 3'd4
    } mem_arb_state_t;

    // Bursts start on a line boundary; single words on a word boundary.
    function automatic logic [31:0] align_addr(input logic [31:0] addr,
                                               input logic        burst,
                                               input int          line_words);
        logic [31:0] w_mask;
        w_mask = burst ? (32'(line_words) * 32'd4 - 32'd1) : 32'd3;
        return addr & ~w_mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module  : mem_bus_arbiter
// Fixed-priority arbiter sharing one memory bus between icache/dcache reads
// and dcache writes; one transaction in flight, write line buffered inside.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int LINE_WORDS = cpu_defs::LINE_WORDS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 rd_req,
    input  logic [1:0][31:0]           rd_addr,
    input  logic [1:0]                 rd_burst,
    output logic [1:0]                 rd_ack,
    output logic [1:0]                 rd_ret_valid,
    output logic [31:0]                ret_data,
    output logic                       ret_last,
    input  logic                       wr_req,
    input  logic [31:0]                wr_addr,
    input  logic                       wr_burst,
    input  logic [3:0]                 wr_strb,
    input  logic [LINE_WORDS*32-1:0]   wr_data,
    output logic                       wr_ack,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic                       mem_we,
    output logic [31:0]                mem_addr,
    output logic [7:0]                 mem_len,
    output logic [3:0]                 mem_strb,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_rvalid,
    input  logic [31:0]                mem_rdata,
    input  logic                       mem_rlast,
    input  logic                       mem_bvalid
);
    import cpu_defs::*;

    localparam int         BEAT_W    = $clog2(LINE_WORDS);
    localparam logic [7:0] BURST_LEN = 8'(LINE_WORDS - 1);

    mem_arb_state_t              r_state;
    logic [31:0]                 r_addr;
    logic [7:0]                  r_len;
    logic [3:0]                  r_strb;
    logic                        r_id;
    logic [LINE_WORDS-1:0][31:0] r_buf;
    logic [BEAT_W-1:0]           r_beat;
    logic [1:0]                  r_ret_valid;
    logic [31:0]                 r_ret_data;
    logic                        r_ret_last;

    logic        w_idle;
    logic        w_wr_win;
    logic        w_dc_win;
    logic        w_ic_win;
    logic        w_rd_id;
    logic        w_last_beat;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_wr_win = w_idle & wr_req;
    assign w_dc_win = w_idle & ~wr_req & rd_req[REQ_DCACHE];
    assign w_ic_win = w_idle & ~wr_req & ~rd_req[REQ_DCACHE] & rd_req[REQ_ICACHE];
    assign w_rd_id  = w_dc_win ? REQ_DCACHE : REQ_ICACHE;

    assign w_last_beat = ({{(8-BEAT_W){1'b0}}, r_beat} == r_len);

    assign wr_ack       = w_wr_win;
    assign rd_ack       = {w_dc_win, w_ic_win};
    assign mem_valid    = (r_state == ST_RD_ADDR) | (r_state == ST_WR_DATA);
    assign mem_we       = (r_state == ST_WR_DATA);
    assign mem_addr     = r_addr;
    assign mem_len      = r_len;
    assign mem_strb     = r_strb;
    assign mem_wdata    = mem_we ? r_buf[r_beat] : 32'd0;
    assign rd_ret_valid = r_ret_valid;
    assign ret_data     = r_ret_data;
    assign ret_last     = r_ret_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= 32'd0;
            r_len       <= 8'd0;
            r_strb      <= 4'd0;
            r_id        <= 1'b0;
            r_buf       <= '0;
            r_beat      <= '0;
            r_ret_valid <= 2'b00;
            r_ret_data  <= 32'd0;
            r_ret_last  <= 1'b0;
        end else begin
            r_ret_valid <= 2'b00;
            r_ret_last  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_win) begin
                        r_addr  <= align_addr(wr_addr, wr_burst, LINE_WORDS);
                        r_len   <= wr_burst ? BURST_LEN : 8'd0;
                        r_strb  <= wr_burst ? 4'hF : wr_strb;
                        r_buf   <= wr_data;
                        r_beat  <= '0;
                        r_state <= ST_WR_DATA;
                    end else if (w_dc_win | w_ic_win) begin
                        r_id    <= w_rd_id;
                        r_addr  <= align_addr(rd_addr[w_rd_id], rd_burst[w_rd_id], LINE_WORDS);
                        r_len   <= rd_burst[w_rd_id] ? BURST_LEN : 8'd0;
                        r_strb  <= 4'hF;
                        r_state <= ST_RD_ADDR;
                    end
                end
                ST_RD_ADDR: begin
                    if (mem_ready) begin
                        r_state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    // Return path is registered: beats appear one cycle after the bus.
                    if (mem_rvalid) begin
                        r_ret_valid <= 2'b01 << r_id;
                        r_ret_data  <= mem_rdata;
                        r_ret_last  <= mem_rlast;
                        if (mem_rlast) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (mem_ready) begin
                        if (w_last_beat) begin
                            r_beat  <= '0;
                            r_state <= ST_WR_RESP;
                        end else begin
                            r_beat  <= r_beat + 1'b1;
                        end
                    end
                end
                ST_WR_RESP: begin
                    // Holding here until the response keeps later reads ordered behind the write.
                    if (mem_bvalid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Directed self-checking bench for mem_bus_arbiter with a return-beat scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    localparam int LW = 4;

    typedef struct packed {
        logic [1:0]  v;
        logic [31:0] d;
        logic        l;
    } ret_t;

    logic                 clk;
    logic                 rst_n;
    logic [1:0]           rd_req;
    logic [1:0][31:0]     rd_addr;
    logic [1:0]           rd_burst;
    logic [1:0]           rd_ack;
    logic [1:0]           rd_ret_valid;
    logic [31:0]          ret_data;
    logic                 ret_last;
    logic                 wr_req;
    logic [31:0]          wr_addr;
    logic                 wr_burst;
    logic [3:0]           wr_strb;
    logic [LW*32-1:0]     wr_data;
    logic                 wr_ack;
    logic                 mem_valid;
    logic                 mem_ready;
    logic                 mem_we;
    logic [31:0]          mem_addr;
    logic [7:0]           mem_len;
    logic [3:0]           mem_strb;
    logic [31:0]          mem_wdata;
    logic                 mem_rvalid;
    logic [31:0]          mem_rdata;
    logic                 mem_rlast;
    logic                 mem_bvalid;

    int   n_assert;
    int   n_fail;
    ret_t sb[$];

    mem_bus_arbiter #(.LINE_WORDS(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_burst(rd_burst), .rd_ack(rd_ack),
        .rd_ret_valid(rd_ret_valid), .ret_data(ret_data), .ret_last(ret_last),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_burst(wr_burst), .wr_strb(wr_strb),
        .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_len(mem_len), .mem_strb(mem_strb),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_rlast(mem_rlast), .mem_bvalid(mem_bvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (mem_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("mem_valid_wait", 64'(mem_valid), 64'd1);
    endtask

    // Address phase of a read: check fields, stall one cycle, then accept.
    task automatic serve_rd(input logic [31:0] exp_addr, input logic [7:0] exp_len);
        wait_valid();
        chk("rd_we", 64'(mem_we), 64'd0);
        chk("rd_addr", 64'(mem_addr), 64'(exp_addr));
        chk("rd_len", 64'(mem_len), 64'(exp_len));
        tick();
        chk("rd_addr_stable", 64'(mem_addr), 64'(exp_addr));
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("rd_valid_drop", 64'(mem_valid), 64'd0);
    endtask

    // Drive nsend read beats out of ntotal; scoreboard predicts each return beat.
    task automatic rd_beats(input logic [1:0] oh, input int nsend, input int ntotal);
        ret_t e;
        logic [31:0] d;
        for (int i = 0; i < nsend; i++) begin
            d          = $urandom;
            mem_rvalid = 1'b1;
            mem_rdata  = d;
            mem_rlast  = (i == ntotal - 1);
            e.v = oh;
            e.d = d;
            e.l = (i == ntotal - 1);
            sb.push_back(e);
            tick();
            mem_rvalid = 1'b0;
            mem_rlast  = 1'b0;
            e = sb.pop_front();
            chk("ret_valid", 64'(rd_ret_valid), 64'(e.v));
            chk("ret_data", 64'(ret_data), 64'(e.d));
            chk("ret_last", 64'(ret_last), 64'(e.l));
            if (i == 0 && ntotal > 1) begin
                tick();
                chk("ret_gap", 64'(rd_ret_valid), 64'd0);
            end
        end
    endtask

    task automatic wr_beats(input logic [LW-1:0][31:0] line, input int nbeats,
                            input int stall_beat, input int stall_n);
        for (int b = 0; b < nbeats; b++) begin
            if (b == stall_beat) begin
                mem_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    chk("wdata_stall", 64'(mem_wdata), 64'(line[b]));
                    tick();
                end
            end
            chk("wr_we", 64'(mem_we), 64'd1);
            chk("wdata", 64'(mem_wdata), 64'(line[b]));
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
        end
        chk("wr_valid_drop", 64'(mem_valid), 64'd0);
    endtask

    task automatic wr_resp(input int dly);
        for (int k = 0; k < dly; k++) begin
            chk("no_ack_in_resp", 64'({rd_ack, wr_ack}), 64'd0);
            tick();
        end
        mem_bvalid = 1'b1;
        tick();
        mem_bvalid = 1'b0;
    endtask

    initial begin
        logic [LW-1:0][31:0] line;
        n_assert   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        rd_req     = 2'b00;
        rd_addr    = '0;
        rd_burst   = 2'b00;
        wr_req     = 1'b0;
        wr_addr    = 32'd0;
        wr_burst   = 1'b0;
        wr_strb    = 4'd0;
        wr_data    = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        mem_rlast  = 1'b0;
        mem_bvalid = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_acks", 64'({rd_ack, wr_ack}), 64'd0);
        chk("rst_ret", 64'({rd_ret_valid, ret_last, ret_data}), 64'd0);
        chk("rst_mem_fields", 64'({mem_we, mem_len, mem_strb}), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        rst_n = 1'b1;
        tick();

        // Icache burst read
        rd_req     = 2'b01;
        rd_addr[0] = 32'h1C00_0014;
        rd_burst   = 2'b01;
        #1;
        chk("ic_ack", 64'(rd_ack), 64'b01);
        chk("ic_no_wr_ack", 64'(wr_ack), 64'd0);
        tick();
        rd_req = 2'b00;
        chk("no_ack_busy", 64'(rd_ack), 64'd0);
        serve_rd(32'h1C00_0010, 8'd3);
        rd_beats(2'b01, 4, 4);

        // All three requesters at once: wr, then dc, then ic
        line       = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
        wr_req     = 1'b1;
        wr_addr    = 32'h0010_0024;
        wr_burst   = 1'b1;
        wr_strb    = 4'h1;
        wr_data    = line;
        rd_req     = 2'b11;
        rd_addr[1] = 32'h0000_2007;
        rd_addr[0] = 32'h0000_3018;
        rd_burst   = 2'b01;
        #1;
        chk("all_wr_ack", 64'(wr_ack), 64'd1);
        chk("all_rd_not_acked", 64'(rd_ack), 64'd0);
        tick();
        wr_req = 1'b0;
        chk("all_rd_wait", 64'(rd_ack), 64'd0);
        chk("wb_addr", 64'(mem_addr), 64'h0010_0020);
        chk("wb_len", 64'(mem_len), 64'd3);
        chk("wb_strb", 64'(mem_strb), 64'hF);
        wr_beats(line, 4, -1, 0);
        wr_resp(2);
        chk("dc_ack_after_b", 64'(rd_ack), 64'b10);
        tick();
        rd_req = 2'b01;
        serve_rd(32'h0000_2004, 8'd0);
        rd_beats(2'b10, 1, 1);
        #1;
        chk("ic_ack_b2b", 64'(rd_ack), 64'b01);
        tick();
        rd_req = 2'b00;
        serve_rd(32'h0000_3010, 8'd3);
        rd_beats(2'b01, 4, 4);

        // Uncached store with a pending dcache read
        wr_req     = 1'b1;
        wr_addr    = 32'hBFAF_8003;
        wr_burst   = 1'b0;
        wr_strb    = 4'b0010;
        line       = {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF};
        wr_data    = line;
        rd_req     = 2'b10;
        rd_addr[1] = 32'h8000_0106;
        rd_burst   = 2'b00;
        #1;
        chk("st_wr_ack", 64'(wr_ack), 64'd1);
        tick();
        wr_req = 1'b0;
        chk("st_addr", 64'(mem_addr), 64'hBFAF_8000);
        chk("st_len", 64'(mem_len), 64'd0);
        chk("st_strb", 64'(mem_strb), 64'b0010);
        wr_beats(line, 1, -1, 0);
        wr_resp(3);
        chk("st_rd_ack", 64'(rd_ack), 64'b10);
        tick();
        rd_req = 2'b00;
        serve_rd(32'h8000_0104, 8'd0);
        rd_beats(2'b10, 1, 1);

        // Line writeback with a 5-cycle stall at beat 2
        line     = {32'h3333_CCCC, 32'h2222_BBBB, 32'h1111_AAAA, 32'h0000_9999};
        wr_req   = 1'b1;
        wr_addr  = 32'h0040_003C;
        wr_burst = 1'b1;
        wr_data  = line;
        #1;
        chk("wb2_ack", 64'(wr_ack), 64'd1);
        tick();
        wr_req = 1'b0;
        chk("wb2_addr", 64'(mem_addr), 64'h0040_0030);
        wr_beats(line, 4, 2, 5);
        wr_resp(1);

        // Reset during RD_DATA beat 2, then normal dcache read
        rd_req     = 2'b10;
        rd_addr[1] = 32'h0000_1234;
        rd_burst   = 2'b10;
        #1;
        chk("rst_case_ack", 64'(rd_ack), 64'b10);
        tick();
        rd_req = 2'b00;
        serve_rd(32'h0000_1230, 8'd3);
        rd_beats(2'b10, 2, 4);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        rst_n      = 1'b0;
        #1;
        chk("abort_ret", 64'({rd_ret_valid, ret_last, ret_data}), 64'd0);
        chk("abort_mem_valid", 64'(mem_valid), 64'd0);
        mem_rvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rd_req     = 2'b10;
        rd_addr[1] = 32'h2000_0048;
        #1;
        chk("post_rst_ack", 64'(rd_ack), 64'b10);
        tick();
        rd_req = 2'b00;
        serve_rd(32'h2000_0040, 8'd3);
        rd_beats(2'b10, 4, 4);

        // Stray bus responses while idle
        tick();
        mem_rvalid = 1'b1;
        mem_rlast  = 1'b1;
        mem_rdata  = 32'hFFFF_0000;
        mem_bvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        mem_bvalid = 1'b0;
        chk("stray_ret", 64'(rd_ret_valid), 64'd0);
        chk("stray_mem_valid", 64'(mem_valid), 64'd0);
        rd_req     = 2'b01;
        rd_addr[0] = 32'h0000_0043;
        rd_burst   = 2'b00;
        #1;
        chk("stray_still_idle", 64'(rd_ack), 64'b01);
        tick();
        rd_req = 2'b00;
        serve_rd(32'h0000_0040, 8'd0);
        rd_beats(2'b01, 1, 1);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
